// File: rtl/conv_psum_acc_pkg.sv
// Shared parameters, types and lane-wise arithmetic helpers for the
// partial-sum accumulator that sits between conv_pe and the quantise stage.
package conv_psum_acc_pkg;

  localparam int TOUT           = 4;    // output channels per PE beat
  localparam int W_PSUM         = 20;   // width of one conv_pe lane
  localparam int W_ACC          = 32;   // accumulator width per lane
  localparam int MAX_W          = 256;  // longest supported row in pixels
  localparam int W_SIZE         = 9;    // column counter / cfg_width width
  localparam int W_CHANNEL      = 9;    // group counter / cfg_n_cgrp width
  localparam int PSUM_BUF_DEPTH = MAX_W;
  localparam int W_ADDR         = $clog2(PSUM_BUF_DEPTH);
  localparam int W_PE_BUS       = TOUT * W_PSUM;
  localparam int W_OUT_BUS      = TOUT * W_ACC;

  localparam logic [W_SIZE-1:0]    SIZE_ZERO  = {W_SIZE{1'b0}};
  localparam logic [W_SIZE-1:0]    SIZE_ONE   = {{(W_SIZE-1){1'b0}}, 1'b1};
  localparam logic [W_SIZE-1:0]    SIZE_MAX_W = W_SIZE'(MAX_W);
  localparam logic [W_CHANNEL-1:0] CGRP_ZERO  = {W_CHANNEL{1'b0}};
  localparam logic [W_CHANNEL-1:0] CGRP_ONE   = {{(W_CHANNEL-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

  // Sign-extend every PE lane to accumulator width; lane positions are kept.
  function automatic logic [W_OUT_BUS-1:0] sext_beat(input logic [W_PE_BUS-1:0] beat);
    logic [W_OUT_BUS-1:0] ext;
    ext = {W_OUT_BUS{1'b0}};
    for (int i = 0; i < TOUT; i++) begin
      ext[i*W_ACC +: W_ACC] = {{(W_ACC-W_PSUM){beat[i*W_PSUM + W_PSUM - 1]}},
                               beat[i*W_PSUM +: W_PSUM]};
    end
    return ext;
  endfunction

  // Lane-wise add, each lane wrapping modulo 2^W_ACC independently.
  function automatic logic [W_OUT_BUS-1:0] add_lanes(input logic [W_OUT_BUS-1:0] a,
                                                     input logic [W_OUT_BUS-1:0] b);
    logic [W_OUT_BUS-1:0] sum;
    sum = {W_OUT_BUS{1'b0}};
    for (int i = 0; i < TOUT; i++) begin
      sum[i*W_ACC +: W_ACC] = a[i*W_ACC +: W_ACC] + b[i*W_ACC +: W_ACC];
    end
    return sum;
  endfunction

endpackage

// File: rtl/conv_psum_acc_chk.sv
// Configuration checker for conv_psum_acc: a row may only be started with a
// width inside 1..MAX_W and at least one channel group.
module conv_psum_acc_chk
  import conv_psum_acc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 idle,
  input  logic [W_SIZE-1:0]    cfg_width,
  input  logic [W_CHANNEL-1:0] cfg_n_cgrp
);

  a_cfg_legal: assert property (@(posedge clk) disable iff (rst)
    (start && idle) |-> ((cfg_width != SIZE_ZERO) && (cfg_width <= SIZE_MAX_W) &&
                         (cfg_n_cgrp != CGRP_ZERO)))
    else $error("conv_psum_acc: row started with unsupported configuration");

endmodule

// File: rtl/conv_psum_acc_psum_buf_ram.sv
// Row-wide partial-sum buffer: simple dual-port RAM, one word per pixel
// column, registered read. Same-address read/write returns the old word;
// the accumulator forwards around that case itself.
module conv_psum_acc_psum_buf_ram
  import conv_psum_acc_pkg::*;
(
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [W_ADDR-1:0]    wr_addr,
  input  logic [W_OUT_BUS-1:0] wr_data,
  input  logic [W_ADDR-1:0]    rd_addr,
  output logic [W_OUT_BUS-1:0] rd_data
);

  logic [W_OUT_BUS-1:0] mem_q [PSUM_BUF_DEPTH];
  logic [W_OUT_BUS-1:0] rd_data_q;

  // Write port: store the updated partial sums of one pixel.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read port: one-cycle registered read of the addressed pixel.
  always_ff @(posedge clk) begin
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/conv_psum_acc.sv
// Partial-sum accumulator: sums the Tout lanes that conv_pe emits per pixel
// over every channel group of a row and emits the totals on the last group.
// Pipeline: S0 = beat accepted + buffer read, S1 = add + write-back,
// outputs registered from S1 (o_vld two cycles after the final beat).
module conv_psum_acc
  import conv_psum_acc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [W_SIZE-1:0]    cfg_width,
  input  logic [W_CHANNEL-1:0] cfg_n_cgrp,
  input  logic                 pe_vld,
  input  logic [W_PE_BUS-1:0]  pe_acc,
  output logic                 o_vld,
  output logic [W_OUT_BUS-1:0] o_data,
  output logic [W_SIZE-1:0]    o_col,
  output logic                 o_row_done,
  output logic                 busy,
  output logic                 err_overrun
);

  // Control state
  state_e               state_q, state_d;
  logic [W_SIZE-1:0]    cfg_width_q, cfg_width_d;
  logic [W_CHANNEL-1:0] cfg_n_cgrp_q, cfg_n_cgrp_d;
  logic [W_SIZE-1:0]    col_q, col_d;
  logic [W_CHANNEL-1:0] cgrp_q, cgrp_d;
  logic                 err_overrun_q, err_overrun_d;

  // S1 stage registers
  logic                 s1_vld_q, s1_vld_d;
  logic                 s1_first_q, s1_first_d;
  logic                 s1_last_q, s1_last_d;
  logic                 s1_row_end_q, s1_row_end_d;
  logic                 s1_fwd_q, s1_fwd_d;
  logic [W_SIZE-1:0]    s1_col_q, s1_col_d;
  logic [W_OUT_BUS-1:0] s1_ext_q, s1_ext_d;
  logic [W_OUT_BUS-1:0] s1_fwd_data_q, s1_fwd_data_d;

  // Output registers
  logic                 o_vld_q, o_vld_d;
  logic [W_OUT_BUS-1:0] o_data_q, o_data_d;
  logic [W_SIZE-1:0]    o_col_q, o_col_d;
  logic                 o_row_done_q, o_row_done_d;
  logic                 busy_q, busy_d;

  // Combinational helpers
  logic                 beat_s;
  logic                 last_col_s;
  logic                 last_grp_s;
  logic                 idle_s;
  logic                 s1_wr_en_s;
  logic [W_OUT_BUS-1:0] rd_data_s;
  logic [W_OUT_BUS-1:0] base_s;
  logic [W_OUT_BUS-1:0] sum_s;

  assign idle_s = (state_q == ST_IDLE);

  // Row FSM, column/group counters and the sticky overrun flag.
  always_comb begin
    state_d       = state_q;
    cfg_width_d   = cfg_width_q;
    cfg_n_cgrp_d  = cfg_n_cgrp_q;
    col_d         = col_q;
    cgrp_d        = cgrp_q;
    err_overrun_d = err_overrun_q;
    beat_s        = 1'b0;
    last_col_s    = (col_q == (cfg_width_q - SIZE_ONE));
    last_grp_s    = (cgrp_q == (cfg_n_cgrp_q - CGRP_ONE));
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_ACC;
          cfg_width_d  = cfg_width;
          cfg_n_cgrp_d = cfg_n_cgrp;
          col_d        = SIZE_ZERO;
          cgrp_d       = CGRP_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
        // A beat with no row open is dropped; it wins over a same-cycle start.
        if (pe_vld) begin
          err_overrun_d = 1'b1;
        end else if (start) begin
          err_overrun_d = 1'b0;
        end else begin
          err_overrun_d = err_overrun_q;
        end
      end
      ST_ACC: begin
        beat_s = pe_vld;
        if (pe_vld) begin
          if (last_col_s) begin
            col_d = SIZE_ZERO;
            if (last_grp_s) begin
              state_d = ST_IDLE;
              cgrp_d  = CGRP_ZERO;
            end else begin
              cgrp_d = cgrp_q + CGRP_ONE;
            end
          end else begin
            col_d = col_q + SIZE_ONE;
          end
        end else begin
          col_d = col_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // S1 accumulate: pick the previous partial sum (forwarded or from RAM) and
  // add the new beat; capture the next beat into S1.
  always_comb begin
    if (s1_fwd_q) begin
      base_s = s1_fwd_data_q;
    end else begin
      base_s = rd_data_s;
    end
    if (s1_first_q) begin
      sum_s = s1_ext_q;
    end else begin
      sum_s = add_lanes(base_s, s1_ext_q);
    end
    s1_wr_en_s    = s1_vld_q && !s1_last_q;
    s1_vld_d      = beat_s;
    s1_col_d      = col_q;
    s1_first_d    = (cgrp_q == CGRP_ZERO);
    s1_last_d     = last_grp_s;
    s1_row_end_d  = last_col_s && last_grp_s;
    s1_ext_d      = sext_beat(pe_acc);
    // The RAM returns stale data when S0 reads the word S1 is writing now.
    s1_fwd_d      = s1_wr_en_s && (s1_col_q == col_q);
    s1_fwd_data_d = sum_s;
  end

  // Output stage: final-group sums leave here; data/col hold between beats.
  always_comb begin
    o_vld_d      = s1_vld_q && s1_last_q;
    o_row_done_d = s1_vld_q && s1_last_q && s1_row_end_q;
    if (s1_vld_q && s1_last_q) begin
      o_data_d = sum_s;
      o_col_d  = s1_col_q;
    end else begin
      o_data_d = o_data_q;
      o_col_d  = o_col_q;
    end
    busy_d = (state_d == ST_ACC) || s1_vld_d;
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cfg_width_q   <= SIZE_ZERO;
      cfg_n_cgrp_q  <= CGRP_ZERO;
      col_q         <= SIZE_ZERO;
      cgrp_q        <= CGRP_ZERO;
      err_overrun_q <= 1'b0;
      s1_vld_q      <= 1'b0;
      s1_first_q    <= 1'b0;
      s1_last_q     <= 1'b0;
      s1_row_end_q  <= 1'b0;
      s1_fwd_q      <= 1'b0;
      s1_col_q      <= SIZE_ZERO;
      s1_ext_q      <= {W_OUT_BUS{1'b0}};
      s1_fwd_data_q <= {W_OUT_BUS{1'b0}};
      o_vld_q       <= 1'b0;
      o_data_q      <= {W_OUT_BUS{1'b0}};
      o_col_q       <= SIZE_ZERO;
      o_row_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cfg_width_q   <= cfg_width_d;
      cfg_n_cgrp_q  <= cfg_n_cgrp_d;
      col_q         <= col_d;
      cgrp_q        <= cgrp_d;
      err_overrun_q <= err_overrun_d;
      s1_vld_q      <= s1_vld_d;
      s1_first_q    <= s1_first_d;
      s1_last_q     <= s1_last_d;
      s1_row_end_q  <= s1_row_end_d;
      s1_fwd_q      <= s1_fwd_d;
      s1_col_q      <= s1_col_d;
      s1_ext_q      <= s1_ext_d;
      s1_fwd_data_q <= s1_fwd_data_d;
      o_vld_q       <= o_vld_d;
      o_data_q      <= o_data_d;
      o_col_q       <= o_col_d;
      o_row_done_q  <= o_row_done_d;
      busy_q        <= busy_d;
    end
  end

  conv_psum_acc_psum_buf_ram u_buf (
    .clk     (clk),
    .wr_en   (s1_wr_en_s),
    .wr_addr (s1_col_q[W_ADDR-1:0]),
    .wr_data (sum_s),
    .rd_addr (col_q[W_ADDR-1:0]),
    .rd_data (rd_data_s)
  );

  conv_psum_acc_chk u_chk (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .idle       (idle_s),
    .cfg_width  (cfg_width),
    .cfg_n_cgrp (cfg_n_cgrp)
  );

  assign o_vld       = o_vld_q;
  assign o_data      = o_data_q;
  assign o_col       = o_col_q;
  assign o_row_done  = o_row_done_q;
  assign busy        = busy_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_conv_psum_acc.sv
// Self-checking bench for conv_psum_acc: a per-pixel integer model of the
// row accumulation predicts every output beat and the cycle it must appear.
module tb_conv_psum_acc;
  import conv_psum_acc_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [W_SIZE-1:0]    cfg_width;
  logic [W_CHANNEL-1:0] cfg_n_cgrp;
  logic                 pe_vld;
  logic [W_PE_BUS-1:0]  pe_acc;
  logic                 o_vld;
  logic [W_OUT_BUS-1:0] o_data;
  logic [W_SIZE-1:0]    o_col;
  logic                 o_row_done;
  logic                 busy;
  logic                 err_overrun;

  conv_psum_acc dut (
    .clk(clk), .rst(rst), .start(start), .cfg_width(cfg_width), .cfg_n_cgrp(cfg_n_cgrp),
    .pe_vld(pe_vld), .pe_acc(pe_acc), .o_vld(o_vld), .o_data(o_data), .o_col(o_col),
    .o_row_done(o_row_done), .busy(busy), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                   due;
    int                   col;
    logic [W_OUT_BUS-1:0] data;
    logic                 rd;
  } exp_t;

  exp_t                 q[$];
  int                   mdl [MAX_W][TOUT];
  int                   tests = 0;
  int                   fails = 0;
  int                   n_out = 0;
  int                   n_rd  = 0;
  logic [W_OUT_BUS-1:0] last_data = '0;
  bit                   chk_en = 1'b0;

  // Compare every output beat against the model queue, cycle-exact.
  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_v;
      exp_v = (q.size() > 0) && (q[0].due == cyc);
      if (o_vld || exp_v || o_row_done) begin
        tests++;
        if (!exp_v) begin
          fails++;
          $display("FAIL out_beat cyc=%0d unexpected o_vld=%0b o_row_done=%0b col=%0d, required no output",
                   cyc, o_vld, o_row_done, o_col);
        end else if (o_vld !== 1'b1 || o_data !== q[0].data || o_col !== W_SIZE'(q[0].col) ||
                     o_row_done !== q[0].rd) begin
          fails++;
          $display("FAIL out_beat cyc=%0d got vld=%0b col=%0d data=%h rd=%0b, required vld=1 col=%0d data=%h rd=%0b",
                   cyc, o_vld, o_col, o_data, o_row_done, q[0].col, q[0].data, q[0].rd);
        end
        if (exp_v) void'(q.pop_front());
      end
      if (o_vld) begin
        n_out++;
        last_data = o_data;
        if (o_row_done) n_rd++;
      end
    end
  end

  task automatic chk(input string nm, input logic [W_OUT_BUS-1:0] act, input logic [W_OUT_BUS-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s got %h, required %h", nm, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [W_PE_BUS-1:0] lanes4(input int a, input int b, input int c, input int d);
    return {W_PSUM'(a), W_PSUM'(b), W_PSUM'(c), W_PSUM'(d)};
  endfunction

  function automatic logic [W_PE_BUS-1:0] gen(input int mode, input int col, input int grp);
    case (mode)
      1:       return lanes4(col, -col, 2 * col, 0);
      2:       return lanes4(3, 3, 3, 3);
      3:       return lanes4(1, 1, 1, 1);
      4:       return (grp == 0) ? lanes4(-5, 0, 0, 'h7FFFF) : lanes4(-7, 0, 0, 1);
      default: return {W_PSUM'($urandom), W_PSUM'($urandom), W_PSUM'($urandom), W_PSUM'($urandom)};
    endcase
  endfunction

  task automatic do_start(input int w, input int ncg);
    start = 1'b1;
    cfg_width = W_SIZE'(w);
    cfg_n_cgrp = W_CHANNEL'(ncg);
    tick(1);
    start = 1'b0;
  endtask

  // One beat for pixel (col, grp); the model accumulates and queues the final sum.
  task automatic beat(input int col, input int grp, input int ncg, input int width,
                      input logic [W_PE_BUS-1:0] d, input bit spurious);
    exp_t e;
    logic signed [W_PSUM-1:0] ln;
    pe_vld = 1'b1;
    pe_acc = d;
    if (spurious) begin
      start = 1'b1;
      cfg_width = W_SIZE'($urandom_range(1, MAX_W));
      cfg_n_cgrp = W_CHANNEL'($urandom_range(1, 7));
    end
    for (int l = 0; l < TOUT; l++) begin
      ln = d[(TOUT-1-l)*W_PSUM +: W_PSUM];
      if (grp == 0) mdl[col][l] = int'(ln);
      else          mdl[col][l] = mdl[col][l] + int'(ln);
    end
    if (grp == ncg - 1) begin
      e.due = cyc + 2;
      e.col = col;
      e.rd  = (col == width - 1);
      e.data = '0;
      for (int l = 0; l < TOUT; l++) e.data[(TOUT-1-l)*W_ACC +: W_ACC] = mdl[col][l];
      q.push_back(e);
    end
    tick(1);
    pe_vld = 1'b0;
    pe_acc = '0;
    start = 1'b0;
  endtask

  task automatic run_beats(input int w, input int ncg, input int mode, input int maxgap, input bit spur);
    for (int g = 0; g < ncg; g++) begin
      for (int c = 0; c < w; c++) begin
        beat(c, g, ncg, w, gen(mode, c, g), spur && ($urandom_range(0, 7) == 0));
        if (maxgap > 0) tick($urandom_range(0, maxgap));
      end
    end
  endtask

  task automatic run_row(input int w, input int ncg, input int mode, input int maxgap, input bit spur);
    do_start(w, ncg);
    run_beats(w, ncg, mode, maxgap, spur);
  endtask

  initial begin
    int o0, r0;
    exp_t keep[$];
    rst = 1'b1; start = 1'b0; cfg_width = W_SIZE'(1); cfg_n_cgrp = W_CHANNEL'(1);
    pe_vld = 1'b0; pe_acc = '0;
    tick(3);
    rst = 1'b0;
    // Reset state
    chk("rst_o_vld", W_OUT_BUS'(o_vld), '0);
    chk("rst_busy", W_OUT_BUS'(busy), '0);
    chk("rst_err", W_OUT_BUS'(err_overrun), '0);
    chk("rst_o_data", o_data, '0);
    chk("rst_o_col", W_OUT_BUS'(o_col), '0);
    chk("rst_row_done", W_OUT_BUS'(o_row_done), '0);
    chk_en = 1'b1;

    // 1: single group, lanes {k,-k,2k,0}
    o0 = n_out; r0 = n_rd;
    run_row(16, 1, 1, 0, 1'b0);
    tick(4);
    chk("t1_count", W_OUT_BUS'(n_out - o0), W_OUT_BUS'(16));
    chk("t1_row_done", W_OUT_BUS'(n_rd - r0), W_OUT_BUS'(1));
    chk("t1_last", last_data, {32'd15, 32'hFFFF_FFF1, 32'd30, 32'd0});
    chk("t1_busy", W_OUT_BUS'(busy), '0);

    // 2: four groups of +3, back-to-back
    o0 = n_out;
    run_row(16, 4, 2, 0, 1'b0);
    tick(4);
    chk("t2_count", W_OUT_BUS'(n_out - o0), W_OUT_BUS'(16));
    chk("t2_last", last_data, {32'd12, 32'd12, 32'd12, 32'd12});

    // 3: sign handling and growth beyond W_PSUM
    run_row(16, 2, 4, 0, 1'b0);
    tick(4);
    chk("t3_last", last_data, {32'hFFFF_FFF4, 32'd0, 32'd0, 32'h0008_0000});

    // 4: width 1, same address every cycle
    o0 = n_out; r0 = n_rd;
    run_row(1, 8, 3, 0, 1'b0);
    tick(4);
    chk("t4_count", W_OUT_BUS'(n_out - o0), W_OUT_BUS'(1));
    chk("t4_row_done", W_OUT_BUS'(n_rd - r0), W_OUT_BUS'(1));
    chk("t4_last", last_data, {32'd8, 32'd8, 32'd8, 32'd8});

    // 5: gapped row aborted by reset at group 1 col 5, then a fresh row
    do_start(16, 2);
    for (int g = 0; g < 2; g++) begin
      for (int c = 0; c < 16; c++) begin
        if (g == 1 && c == 5) break;
        beat(c, g, 2, 16, gen(0, c, g), 1'b0);
        tick($urandom_range(0, 3));
      end
    end
    rst = 1'b1;
    keep = {};
    foreach (q[i]) if (q[i].due <= cyc) keep.push_back(q[i]);
    q = keep;
    tick(1);
    rst = 1'b0;
    chk("t5_busy_after_rst", W_OUT_BUS'(busy), '0);
    tick(4);
    o0 = n_out;
    run_row(16, 1, 0, 3, 1'b0);
    tick(4);
    chk("t5_count", W_OUT_BUS'(n_out - o0), W_OUT_BUS'(16));

    // 6: beat while idle sets the sticky flag, start clears it
    o0 = n_out;
    pe_vld = 1'b1; pe_acc = lanes4(9, 9, 9, 9);
    tick(1);
    pe_vld = 1'b0; pe_acc = '0;
    tick(3);
    chk("t6_err_set", W_OUT_BUS'(err_overrun), W_OUT_BUS'(1));
    chk("t6_no_out", W_OUT_BUS'(n_out - o0), '0);
    do_start(4, 1);
    chk("t6_err_clr", W_OUT_BUS'(err_overrun), '0);
    run_beats(4, 1, 0, 0, 1'b0);
    tick(3);
    // start with a same-cycle beat: beat dropped and flagged
    start = 1'b1; cfg_width = W_SIZE'(3); cfg_n_cgrp = W_CHANNEL'(2);
    pe_vld = 1'b1; pe_acc = lanes4(100, 100, 100, 100);
    tick(1);
    start = 1'b0; pe_vld = 1'b0; pe_acc = '0;
    chk("t6_err_same_cycle", W_OUT_BUS'(err_overrun), W_OUT_BUS'(1));
    chk("t6_busy", W_OUT_BUS'(busy), W_OUT_BUS'(1));
    run_beats(3, 2, 0, 1, 1'b0);
    tick(4);

    // Full-depth row and randomized rows with spurious starts mid-row
    run_row(MAX_W, 2, 0, 0, 1'b1);
    for (int r = 0; r < 8; r++) begin
      run_row((r < 2) ? $urandom_range(1, 3) : $urandom_range(1, 24),
              $urandom_range(1, 5), 0, $urandom_range(0, 2), 1'b1);
    end
    tick(5);
    chk("queue_drained", W_OUT_BUS'(q.size()), '0);
    chk("final_busy", W_OUT_BUS'(busy), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
